// File: rtl/seq_normalizer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_normalizer_pkg
// Function : Shared types for the iterative leading-one normalizer.
// Revision : 1.0
// ============================================================================
package seq_normalizer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : seq_normalizer_pkg
`default_nettype wire

// File: rtl/seq_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : seq_normalizer
// Function : Shifts a word one bit per clock until its leading one reaches the
//            selected edge; reports the normalized word and the shift count.
// Revision : 1.0
// ============================================================================
module seq_normalizer
  import seq_normalizer_pkg::*;
#(
  parameter int N = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2**N-1:0]  a_i,
  input  logic             lr_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [2**N-1:0]  y_o,
  output logic [N-1:0]     amt_o,
  output logic             zero_o
);

  localparam int W = 2**N;

  state_t         state_q, state_d;
  logic [W-1:0]   work_q,  work_d;
  logic [N-1:0]   cnt_q,   cnt_d;
  logic           dir_q,   dir_d;
  logic [W-1:0]   y_q,     y_d;
  logic [N-1:0]   amt_q,   amt_d;
  logic           zero_q,  zero_d;
  logic           target_bit;

  assign target_bit = dir_q ? work_q[0] : work_q[W-1];

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    y_d     = y_q;
    amt_d   = amt_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          work_d = a_i;
          dir_d  = lr_i;
          cnt_d  = '0;
          if (a_i == '0) begin
            // Nothing to normalize: publish the zero result without shifting.
            y_d     = '0;
            amt_d   = '0;
            zero_d  = 1'b1;
            state_d = DONE;
          end else begin
            zero_d  = 1'b0;
            state_d = SHIFT;
          end
        end
      end

      SHIFT: begin
        if (target_bit) begin
          y_d     = work_q;
          amt_d   = cnt_q;
          state_d = DONE;
        end else begin
          work_d = dir_q ? (work_q >> 1) : (work_q << 1);
          cnt_d  = cnt_q + N'(1);
        end
      end

      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      y_q     <= '0;
      amt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      y_q     <= y_d;
      amt_q   <= amt_d;
      zero_q  <= zero_d;
    end
  end

  // Ready depends only on the state register and reset, never on the handshakes.
  assign in_ready_o  = (state_q == IDLE) && !reset_i;
  assign out_valid_o = (state_q == DONE);
  assign y_o         = y_q;
  assign amt_o       = amt_q;
  assign zero_o      = zero_q;

endmodule : seq_normalizer
`default_nettype wire
